alu_core: RTL and testbench

- Synthesizable 8-bit ALU: the DUT driven and monitored by the team's ALU bus-functional model.
- Accepts operands and an opcode under a start/done handshake.
- Logic ops and add complete in one cycle; multiply completes in MUL_LATENCY cycles.
- Sits directly downstream of the BFM driver; the command and result monitors observe its pins.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_if.sv | 17 +
 rtl/alu_mul_seq.sv | 58 +++++
 rtl/alu_core.sv | 131 +++++++++++++
 tb/tb_alu_core.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: opcode encodings, FSM states and the
// single-cycle datapath helper used by the top-level controller.
package alu_pkg;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      ARM  = 2'd2
   } state_t;

   typedef logic [15:0] result_t;

   // Single-cycle operations; mul is handled by the sequential multiplier.
   function automatic result_t alu_single_op(input logic [2:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
      result_t r;
      case (op)
         OP_ADD:  r = {7'd0, {1'b0, a} + {1'b0, b}};
         OP_AND:  r = {8'd0, a & b};
         OP_XOR:  r = {8'd0, a ^ b};
         default: r = 16'h0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_if.sv
// Command/result bus between the ALU driver (master) and alu_core (slave).
interface alu_if;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [2:0]  op;
   logic        start;
   logic        done;
   logic [15:0] result;
   logic        busy;
   logic        err;

   modport master (output A, output B, output op, output start,
                   input done, input result, input busy, input err);

   modport slave  (input A, input B, input op, input start,
                   output done, output result, output busy, output err);
endinterface

// File: rtl/alu_mul_seq.sv
// Latched-operand multiplier: captures operands on load and counts down
// MUL_LATENCY edges; 'last' marks the edge on which the product is final.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic       abort,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       last,
   output result_t    product
);

   localparam logic [3:0] LAT = 4'(MUL_LATENCY);

   logic [3:0] cnt_q, cnt_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;

   // Next-state for the down-counter and the operand latches.
   always_comb begin
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      if (load) begin
         cnt_d = LAT;
         a_d   = a;
         b_d   = b;
      end else if (abort) begin
         cnt_d = 4'd0;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter and operand registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= 4'd0;
         a_q   <= 8'd0;
         b_q   <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
         a_q   <= a_d;
         b_q   <= b_d;
      end
   end

   assign last    = (cnt_q == 4'd1) && !abort;
   assign product = {8'd0, a_q} * {8'd0, b_q};

endmodule

// File: rtl/alu_core.sv
// 8-bit ALU with start/done handshake: add/and/xor in one cycle, mul in
// MUL_LATENCY cycles, sticky error on illegal opcodes.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 3
) (
   input  logic  clk,
   input  logic  reset_n,
   alu_if.slave  bus
);

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   result_t    result_q, result_d;
   logic       done_q, done_d;
   logic       busy_q, busy_d;
   logic       err_q, err_d;
   logic       rearm_q, rearm_d;

   logic       mul_load_s;
   logic       mul_abort_s;
   logic       mul_last_s;
   result_t    mul_product_s;

   assign mul_load_s  = (state_q == IDLE) && bus.start && !rearm_q && (bus.op == OP_MUL);
   assign mul_abort_s = (state_q == EXEC) && !bus.start;

   alu_mul_seq #(.MUL_LATENCY(MUL_LATENCY)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (mul_load_s),
      .abort   (mul_abort_s),
      .a       (bus.A),
      .b       (bus.B),
      .last    (mul_last_s),
      .product (mul_product_s)
   );

   // Controller next-state: acceptance, completion, abort and re-arm.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      done_d   = 1'b0;
      err_d    = err_q;
      rearm_d  = rearm_q;
      case (state_q)
         IDLE: begin
            if (!bus.start) begin
               rearm_d = 1'b0;
            end else if (!rearm_q) begin
               op_d = bus.op;
               a_d  = bus.A;
               b_d  = bus.B;
               case (bus.op)
                  OP_NOP: rearm_d = 1'b1;
                  OP_ADD, OP_AND, OP_XOR, OP_MUL: state_d = EXEC;
                  default: begin
                     err_d   = 1'b1;
                     state_d = ARM;
                  end
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            if (!bus.start) begin
               state_d = IDLE;
            end else if (op_q == OP_MUL) begin
               if (mul_last_s) begin
                  result_d = mul_product_s;
                  done_d   = 1'b1;
                  state_d  = ARM;
               end else begin
                  state_d = EXEC;
               end
            end else begin
               result_d = alu_single_op(op_q, a_q, b_q);
               done_d   = 1'b1;
               state_d  = ARM;
            end
         end
         ARM: begin
            if (!bus.start) begin
               state_d = IDLE;
            end else begin
               state_d = ARM;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == EXEC);
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         op_q     <= OP_NOP;
         a_q      <= 8'd0;
         b_q      <= 8'd0;
         result_q <= 16'h0000;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         rearm_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         rearm_q  <= rearm_d;
      end
   end

   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core; inputs change and outputs are
// sampled on the falling clock edge.
module tb_alu_core;

   localparam logic [2:0] T_NOP = 3'b000;
   localparam logic [2:0] T_ADD = 3'b001;
   localparam logic [2:0] T_AND = 3'b010;
   localparam logic [2:0] T_XOR = 3'b011;
   localparam logic [2:0] T_MUL = 3'b100;
   localparam logic [2:0] T_ILL = 3'b101;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   alu_if bus ();

   alu_core #(.MUL_LATENCY(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      bus.A     = a;
      bus.B     = b;
      bus.op    = op;
      bus.start = 1'b1;
   endtask

   // Counts falling edges until done is seen; seen=0 means the bound expired.
   task automatic wait_done(input int max, output int seen);
      seen = 0;
      for (int k = 1; k <= max; k++) begin
         tick();
         if (bus.done) begin
            seen = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.start = 1'b0; bus.A = 8'd0; bus.B = 8'd0; bus.op = T_NOP;
      tick(); tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
      checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp 0000", bus.result); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      logic extra;
      issue(8'hFF, 8'h01, T_ADD);
      tick();
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL add_exec busy=%b done=%b exp busy=1 done=0", bus.busy, bus.done); end
      tick();
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL add_done got %b exp 1", bus.done); end
      checks++; if (bus.result !== 16'h0100) begin errors++; $display("FAIL add_result got %h exp 0100", bus.result); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL add_busy_drop got %b exp 0", bus.busy); end
      extra = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.done) extra = 1'b1;
      end
      checks++; if (extra !== 1'b0) begin errors++; $display("FAIL add_held_start second done seen=%b exp 0", extra); end
      bus.start = 1'b0;
      tick();
   endtask

   task automatic test_mul();
      int seen;
      issue(8'hFF, 8'hFF, T_MUL);
      wait_done(20, seen);
      checks++; if (seen != 4) begin errors++; $display("FAIL mul_latency got %0d falling edges exp 4 (0=timeout)", seen); end
      checks++; if (bus.result !== 16'hFE01) begin errors++; $display("FAIL mul_ff_result got %h exp FE01", bus.result); end
      bus.start = 1'b0;
      tick();
      issue(8'h00, 8'hFF, T_MUL);
      wait_done(20, seen);
      checks++; if (seen != 4) begin errors++; $display("FAIL mul_zero_latency got %0d exp 4", seen); end
      checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL mul_zero_result got %h exp 0000", bus.result); end
      bus.start = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      issue(8'hF0, 8'h3C, T_AND);
      tick(); tick();
      checks++; if (bus.done !== 1'b1 || bus.result !== 16'h0030) begin errors++; $display("FAIL and_result done=%b got %h exp 0030", bus.done, bus.result); end
      bus.start = 1'b0;
      tick();
      issue(8'hF0, 8'h3C, T_XOR);
      tick();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL xor_accept busy got %b exp 1", bus.busy); end
      tick();
      checks++; if (bus.done !== 1'b1 || bus.result !== 16'h00CC) begin errors++; $display("FAIL xor_result done=%b got %h exp 00CC", bus.done, bus.result); end
      bus.start = 1'b0;
      tick();
   endtask

   task automatic test_nop();
      issue(8'h02, 8'h03, T_ADD);
      tick(); tick();
      checks++; if (bus.result !== 16'h0005) begin errors++; $display("FAIL nop_pre_add got %h exp 0005", bus.result); end
      bus.start = 1'b0;
      tick();
      issue(8'h77, 8'h11, T_NOP);
      tick();
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 16'h0005) begin errors++; $display("FAIL nop_effect done=%b busy=%b result=%h exp 0 0 0005", bus.done, bus.busy, bus.result); end
      issue(8'h07, 8'h01, T_ADD);
      tick(); tick();
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 16'h0005) begin errors++; $display("FAIL nop_rearm done=%b busy=%b result=%h exp 0 0 0005", bus.done, bus.busy, bus.result); end
      bus.start = 1'b0;
      tick();
      issue(8'h04, 8'h04, T_ADD);
      tick(); tick();
      checks++; if (bus.done !== 1'b1 || bus.result !== 16'h0008) begin errors++; $display("FAIL nop_next_add done=%b got %h exp 0008", bus.done, bus.result); end
      bus.start = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_mul();
      int   seen;
      logic pulsed;
      issue(8'h12, 8'h34, T_MUL);
      tick(); tick();
      reset_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.result !== 16'h0000 || bus.done !== 1'b0) begin errors++; $display("FAIL midmul_reset busy=%b result=%h done=%b exp 0 0000 0", bus.busy, bus.result, bus.done); end
      bus.start = 1'b0;
      tick();
      reset_n = 1'b1;
      pulsed = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.done) pulsed = 1'b1;
      end
      checks++; if (pulsed !== 1'b0) begin errors++; $display("FAIL midmul_no_done got %b exp 0", pulsed); end
      issue(8'h12, 8'h34, T_MUL);
      wait_done(20, seen);
      checks++; if (seen != 4 || bus.result !== 16'h03A8) begin errors++; $display("FAIL midmul_after latency=%0d result=%h exp 4 03A8", seen, bus.result); end
      bus.start = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      logic pulsed;
      issue(8'h10, 8'h10, T_MUL);
      tick();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b exp 1", bus.busy); end
      bus.start = 1'b0;
      pulsed = 1'b0;
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_drop got %b exp 0", bus.busy); end
      for (int i = 0; i < 4; i++) begin
         if (bus.done) pulsed = 1'b1;
         tick();
      end
      checks++; if (pulsed !== 1'b0 || bus.result !== 16'h03A8) begin errors++; $display("FAIL abort_no_done done=%b result=%h exp 0 03A8", pulsed, bus.result); end
   endtask

   task automatic test_illegal();
      logic pulsed;
      issue(8'h01, 8'h01, T_ILL);
      tick();
      checks++; if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL illegal_err err=%b done=%b busy=%b exp 1 0 0", bus.err, bus.done, bus.busy); end
      pulsed = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (bus.done) pulsed = 1'b1;
      end
      checks++; if (pulsed !== 1'b0) begin errors++; $display("FAIL illegal_no_done got %b exp 0", pulsed); end
      bus.start = 1'b0;
      tick();
      issue(8'h01, 8'h02, T_ADD);
      tick(); tick();
      checks++; if (bus.done !== 1'b1 || bus.result !== 16'h0003) begin errors++; $display("FAIL illegal_then_add done=%b got %h exp 0003", bus.done, bus.result); end
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", bus.err); end
      bus.start = 1'b0;
      tick();
   endtask

   task automatic test_reset_held_start();
      reset_n = 1'b0;
      issue(8'h09, 8'h09, T_ADD);
      #1;
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_clears_err got %b exp 0", bus.err); end
      tick();
      reset_n = 1'b1;
      tick();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL held_start_accept busy got %b exp 1", bus.busy); end
      tick();
      checks++; if (bus.done !== 1'b1 || bus.result !== 16'h0012) begin errors++; $display("FAIL held_start_result done=%b got %h exp 0012", bus.done, bus.result); end
      bus.start = 1'b0;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_mul();
      test_back_to_back();
      test_nop();
      test_reset_mid_mul();
      test_abort();
      test_illegal();
      test_reset_held_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
